// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the register hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int SB_NREG  = 32;
  localparam int SB_CNT_W = 2;
  localparam int SB_IDX_W = $clog2(SB_NREG);

  typedef logic [SB_IDX_W-1:0] reg_idx_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = {SB_CNT_W{1'b1}};
  localparam logic    SB_RST     = 1'b1;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             nonzero,
  output logic             at_max,
  output logic             err
);

  localparam logic [CNT_W+1:0] MAX_EXT   = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   EXT_ZEROS = {(CNT_W+1){1'b0}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W+1:0] up_s, dn_s, diff_s;

  // Next count: inc minus up to two decrements, clamped at both ends.
  always_comb begin
    up_s   = {2'b00, cnt_q} + {EXT_ZEROS, inc};
    dn_s   = {EXT_ZEROS, dec_a} + {EXT_ZEROS, dec_b};
    diff_s = up_s - dn_s;
    cnt_d  = cnt_q;
    err    = 1'b0;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (up_s < dn_s) begin
      cnt_d = CNT_ZERO;
      err   = 1'b1;
    end else if (diff_s > MAX_EXT) begin
      cnt_d = CNT_MAX;
      err   = 1'b1;
    end else begin
      cnt_d = diff_s[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == SB_RST) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;
  assign nonzero = (cnt_q != CNT_ZERO);
  assign at_max  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue scheduler: stalls decode on RAW hazards or a saturated destination counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int   NREG      = SB_NREG,
  parameter int   CNT_W     = SB_CNT_W,
  parameter logic BYPASS_WB = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          issue_valid,
  input  logic [$clog2(NREG)-1:0]       issue_rs1,
  input  logic [$clog2(NREG)-1:0]       issue_rs2,
  input  logic [$clog2(NREG)-1:0]       issue_rd,
  input  logic                          issue_has_rs1,
  input  logic                          issue_has_rs2,
  input  logic                          issue_has_rd,
  output logic                          issue_rdy,
  output logic                          issue_fire,
  input  logic                          wb_valid,
  input  logic [$clog2(NREG)-1:0]       wb_rd,
  input  logic                          kill_valid,
  input  logic [$clog2(NREG)-1:0]       kill_rd,
  input  logic                          flush,
  output logic [NREG-1:0]               busy_mask,
  output logic [$clog2(NREG)+CNT_W-1:0] inflight,
  output logic                          sb_err
);

  localparam int               IDX_W    = $clog2(NREG);
  localparam int               INF_W    = IDX_W + CNT_W;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREG-1:0][CNT_W-1:0] cnt_s, nxt_s;
  logic [NREG-1:0]            nonzero_s, at_max_s, err_s;
  logic                       rs1_hz_s, rs2_hz_s, sat_hz_s;
  logic [INF_W-1:0]           inflight_q, inflight_d;
  logic                       sb_err_q, sb_err_d;

  // A lone pending write retiring this very cycle (and not also killed) no longer blocks a reader.
  function automatic logic src_hz(input logic has, input logic [IDX_W-1:0] rs,
                                  input logic [CNT_W-1:0] c);
    logic waive;
    waive = BYPASS_WB && (c == CNT_ONE) && wb_valid && (wb_rd == rs)
            && !(kill_valid && (kill_rd == rs));
    return has && (rs != IDX_ZERO) && (c != CNT_ZERO) && !waive;
  endfunction

  // Hazard detection and issue handshake.
  always_comb begin
    rs1_hz_s   = src_hz(issue_has_rs1, issue_rs1, cnt_s[issue_rs1]);
    rs2_hz_s   = src_hz(issue_has_rs2, issue_rs2, cnt_s[issue_rs2]);
    sat_hz_s   = issue_has_rd && (issue_rd != IDX_ZERO) && at_max_s[issue_rd];
    issue_rdy  = !rs1_hz_s && !rs2_hz_s && !sat_hz_s;
    issue_fire = issue_valid && issue_rdy && en && !flush;
  end

  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    if (r == 0) begin : g_x0
      assign cnt_s[r]     = CNT_ZERO;
      assign nxt_s[r]     = CNT_ZERO;
      assign nonzero_s[r] = 1'b0;
      assign at_max_s[r]  = 1'b0;
      assign err_s[r]     = 1'b0;
    end else begin : g_xr
      localparam logic [IDX_W-1:0] R_IDX = IDX_W'(r);
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .inc     (issue_fire && issue_has_rd && (issue_rd == R_IDX)),
        .dec_a   (wb_valid && (wb_rd == R_IDX)),
        .dec_b   (kill_valid && (kill_rd == R_IDX)),
        .cnt     (cnt_s[r]),
        .cnt_nxt (nxt_s[r]),
        .nonzero (nonzero_s[r]),
        .at_max  (at_max_s[r]),
        .err     (err_s[r])
      );
    end
  end

  // Inflight tracks the post-clamp sum so it can never drift from the per-register counts.
  always_comb begin
    inflight_d = {INF_W{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      inflight_d = inflight_d + {{IDX_W{1'b0}}, nxt_s[r]};
    end
    sb_err_d = sb_err_q || (|err_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == SB_RST) begin
      inflight_q <= {INF_W{1'b0}};
      sb_err_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign busy_mask = nonzero_s;
  assign inflight  = inflight_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (NREG=32, CNT_W=2, BYPASS_WB=1).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, en, issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd, kill_rd;
  logic        issue_has_rs1, issue_has_rs2, issue_has_rd;
  logic        issue_rdy, issue_fire, wb_valid, kill_valid, flush;
  logic [31:0] busy_mask;
  logic [6:0]  inflight;
  logic        sb_err;
  int          checks   = 0;
  int          failures = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .en(en), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_has_rs1(issue_has_rs1), .issue_has_rs2(issue_has_rs2), .issue_has_rd(issue_has_rd),
    .issue_rdy(issue_rdy), .issue_fire(issue_fire),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .flush(flush), .busy_mask(busy_mask), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_has_rs1 = 1'b0; issue_has_rs2 = 1'b0; issue_has_rd = 1'b0;
    issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; kill_valid = 1'b0; kill_rd = 5'd0; flush = 1'b0;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic hrd,
                           input logic [4:0] rs1, input logic h1,
                           input logic [4:0] rs2, input logic h2);
    issue_valid = v; issue_rd = rd; issue_has_rd = hrd;
    issue_rs1 = rs1; issue_has_rs1 = h1; issue_rs2 = rs2; issue_has_rs2 = h2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    idle();
    tick(); tick();
    check("rst_busy", busy_mask, 32'h0);
    check("rst_inflight", {25'd0, inflight}, 32'd0);
    check("rst_err", {31'd0, sb_err}, 32'd0);
    rst = 1'b0;
    tick();

    // x5 = x1 + x2 from clean state
    set_issue(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
    #1;
    check("first_rdy", {31'd0, issue_rdy}, 32'd1);
    check("first_fire", {31'd0, issue_fire}, 32'd1);
    tick();
    idle();
    #1;
    check("first_busy", busy_mask, 32'h0000_0020);
    check("first_inflight", {25'd0, inflight}, 32'd1);

    // en low blocks firing but not readiness
    en = 1'b0;
    set_issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1;
    check("en_rdy", {31'd0, issue_rdy}, 32'd1);
    check("en_fire", {31'd0, issue_fire}, 32'd0);
    tick();
    en = 1'b1;
    idle();
    #1;
    check("en_inflight", {25'd0, inflight}, 32'd1);

    // x6 reads x5: RAW stall, then fires in the writeback cycle
    set_issue(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    check("raw_rdy0", {31'd0, issue_rdy}, 32'd0);
    tick();
    check("raw_rdy1", {31'd0, issue_rdy}, 32'd0);
    check("raw_fire1", {31'd0, issue_fire}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    check("bypass_rdy", {31'd0, issue_rdy}, 32'd1);
    check("bypass_fire", {31'd0, issue_fire}, 32'd1);
    tick();
    idle();
    #1;
    check("raw_busy", busy_mask, 32'h0000_0040);
    check("raw_inflight", {25'd0, inflight}, 32'd1);

    // three writes to x7 saturate, a fourth stalls
    set_issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sat_fill_fire", {31'd0, issue_fire}, 32'd1);
      tick();
    end
    check("sat_inflight", {25'd0, inflight}, 32'd4);
    check("sat_rdy", {31'd0, issue_rdy}, 32'd0);
    tick();
    check("sat_hold_inflight", {25'd0, inflight}, 32'd4);
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0; wb_rd = 5'd0;
    #1;
    check("sat_release_fire", {31'd0, issue_fire}, 32'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    check("sat_after_inflight", {25'd0, inflight}, 32'd4);
    check("sat_again_rdy", {31'd0, issue_rdy}, 32'd0);
    idle();

    // x9 at 2, then issue+wb+kill to x9 in one cycle
    set_issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    check("x9_inflight2", {25'd0, inflight}, 32'd6);
    wb_valid = 1'b1; wb_rd = 5'd9; kill_valid = 1'b1; kill_rd = 5'd9;
    #1;
    check("x9_net_fire", {31'd0, issue_fire}, 32'd1);
    tick();
    idle();
    #1;
    check("x9_inflight", {25'd0, inflight}, 32'd5);
    check("x9_err", {31'd0, sb_err}, 32'd0);
    // cnt[9] == 1: reader is waived only by a same-cycle wb to x9
    set_issue(1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    #1;
    check("x9_cnt1_stall", {31'd0, issue_rdy}, 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd9;
    #1;
    check("x9_cnt1_bypass", {31'd0, issue_rdy}, 32'd1);
    kill_valid = 1'b1; kill_rd = 5'd9;
    #1;
    check("x9_kill_no_bypass", {31'd0, issue_rdy}, 32'd0);
    idle();

    // underflow on x4 sets a sticky error
    wb_valid = 1'b1; wb_rd = 5'd4;
    tick();
    idle();
    #1;
    check("uf_err", {31'd0, sb_err}, 32'd1);
    check("uf_inflight", {25'd0, inflight}, 32'd5);
    check("uf_busy", busy_mask, 32'h0000_02C0);
    tick(); tick();
    check("uf_err_sticky", {31'd0, sb_err}, 32'd1);

    // flush beats a same-cycle issue
    set_issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_fire", {31'd0, issue_fire}, 32'd0);
    tick();
    idle();
    #1;
    check("flush_busy", busy_mask, 32'h0);
    check("flush_inflight", {25'd0, inflight}, 32'd0);
    check("flush_err_kept", {31'd0, sb_err}, 32'd1);

    // register 0 is never tracked
    set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    check("x0_fire", {31'd0, issue_fire}, 32'd1);
    tick();
    idle();
    #1;
    check("x0_inflight", {25'd0, inflight}, 32'd0);
    check("x0_busy", busy_mask, 32'h0);

    // asynchronous reset mid-operation
    set_issue(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    idle();
    #1;
    check("pre_rst_busy", busy_mask, 32'h0000_0800);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy_mask, 32'h0);
    check("async_rst_inflight", {25'd0, inflight}, 32'd0);
    check("async_rst_err", {31'd0, sb_err}, 32'd0);
    tick();
    rst = 1'b0;

    // wb/kill to x0 ignored, no error
    wb_valid = 1'b1; wb_rd = 5'd0; kill_valid = 1'b1; kill_rd = 5'd0;
    tick();
    idle();
    #1;
    check("x0_wb_err", {31'd0, sb_err}, 32'd0);
    check("x0_wb_inflight", {25'd0, inflight}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
